// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the interrupt controller
package int_ctrl_pkg;

    localparam int NIRQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [2:0] OFF_IE     = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_PEND   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_VEC0   = 3'd4;

    // Fixed priority: index 0 wins.
    function automatic logic [1:0] lowest_set(input logic [NIRQ-1:0] v);
        lowest_set = 2'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = i[1:0];
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - 2-flop synchronizer plus rising-edge detector for one source
module irq_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic irq_i,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-triggered 4-source interrupt controller with register window
module interrupt_controller #(
    parameter logic [7:0] BASE = 8'hF0,
    parameter int         NIRQ = int_ctrl_pkg::NIRQ
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] irq,
    input  logic [7:0]      addr,
    input  logic [7:0]      w_data,
    input  logic            w_en,
    output logic [7:0]      r_data,
    input  logic            cpu_ret,
    output logic            int_req,
    output logic [7:0]      int_en,
    output logic [7:0]      int_vec
);
    import int_ctrl_pkg::*;

    logic [NIRQ-1:0] rise;

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .irq_i   (irq[g]),
            .rise_o  (rise[g])
        );
    end

    state_e          state_q, state_d;
    logic            ie_q;
    logic [NIRQ-1:0] mask_q, pend_q, pend_d;
    logic [1:0]      active_q, active_d;
    logic [7:0]      vec_q [4];
    logic [7:0]      last_vec_q;
    logic [7:0]      off;
    logic            in_win, wr, dispatch, busy;
    logic [NIRQ-1:0] eligible;

    assign off      = addr - BASE;
    assign in_win   = off < 8'd8;
    assign wr       = w_en & in_win;
    assign eligible = pend_q & mask_q;
    assign dispatch = ie_q & (|eligible);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            active_q <= 2'd0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (dispatch) state_d = ST_REQ;
            ST_REQ:     state_d = ST_SERVICE;
            ST_SERVICE: if (cpu_ret) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int_req = (state_q == ST_REQ);
        busy    = (state_q != ST_IDLE);
    end

    always_comb begin
        active_d = active_q;
        if (state_q == ST_IDLE && dispatch) active_d = lowest_set(eligible);
    end

    // A fresh edge always survives a clear in the same cycle.
    always_comb begin
        pend_d = pend_q;
        if (wr && off[2:0] == OFF_PEND) pend_d = pend_d & ~w_data[NIRQ-1:0];
        if (state_q == ST_REQ) pend_d[active_q] = 1'b0;
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ie_q       <= 1'b0;
            mask_q     <= '0;
            last_vec_q <= 8'h00;
            for (int i = 0; i < 4; i++) vec_q[i] <= 8'h00;
        end else begin
            if (state_q == ST_REQ) last_vec_q <= vec_q[active_q];
            if (wr) begin
                case (off[2:0])
                    OFF_IE:               ie_q   <= w_data[0];
                    OFF_MASK:             mask_q <= w_data[NIRQ-1:0];
                    OFF_PEND, OFF_STATUS: ;
                    default:              vec_q[off[1:0]] <= w_data;
                endcase
            end
        end
    end

    always_comb begin
        r_data = 8'h00;
        if (in_win) begin
            case (off[2:0])
                OFF_IE:     r_data = {7'b0, ie_q};
                OFF_MASK:   r_data = {{(8-NIRQ){1'b0}}, mask_q};
                OFF_PEND:   r_data = {{(8-NIRQ){1'b0}}, pend_q};
                OFF_STATUS: r_data = {busy, 5'b0, active_q};
                default:    r_data = vec_q[off[1:0]];
            endcase
        end
    end

    assign int_en  = {7'b0, ie_q};
    assign int_vec = (state_q == ST_REQ) ? vec_q[active_q] : last_vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] irq = 4'h0;
    logic [7:0] addr = 8'h00;
    logic [7:0] w_data = 8'h00;
    logic       w_en = 1'b0;
    logic       cpu_ret = 1'b0;
    logic [7:0] r_data, int_en, int_vec;
    logic       int_req;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    interrupt_controller #(.BASE(8'hF0), .NIRQ(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .irq     (irq),
        .addr    (addr),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_data  (r_data),
        .cpu_ret (cpu_ret),
        .int_req (int_req),
        .int_en  (int_en),
        .int_vec (int_vec)
    );

    always #5 clock = ~clock;

    // Reference model: irq sample history, register file and a dispatch phase.
    logic [3:0] h1, h2, h3, m_rise, m_np;
    bit         m_ie;
    logic [3:0] m_mask, m_pend;
    logic [7:0] m_vec [4];
    logic [7:0] m_last;
    int         m_phase;   // 0 idle, 1 requesting, 2 in service
    int         m_active;
    int         m_off;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h1 = 0; h2 = 0; h3 = 0;
            m_ie = 0; m_mask = 0; m_pend = 0; m_last = 0;
            m_phase = 0; m_active = 0;
            for (int i = 0; i < 4; i++) m_vec[i] = 8'h00;
        end else begin
            m_rise = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = irq;
            m_np = m_pend;
            if (m_phase == 0) begin
                if (m_ie && (m_pend & m_mask) != 0) begin
                    m_phase = 1;
                    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) m_active = i;
                end
            end else if (m_phase == 1) begin
                m_np[m_active] = 1'b0;
                m_last = m_vec[m_active];
                m_phase = 2;
            end else if (cpu_ret) begin
                m_phase = 0;
            end
            m_off = addr;
            m_off = m_off - 240;
            if (w_en && m_off >= 0 && m_off < 8) begin
                if (m_off == 0) m_ie = w_data[0];
                else if (m_off == 1) m_mask = w_data[3:0];
                else if (m_off == 2) m_np = m_np & ~w_data[3:0];
                else if (m_off >= 4) m_vec[m_off-4] = w_data;
            end
            m_pend = m_np | m_rise;
        end
    end

    function automatic logic [7:0] exp_rdata(input logic [7:0] a);
        int o;
        logic [1:0] act;
        o = a;
        o = o - 240;
        act = m_active[1:0];
        if (o < 0 || o > 7) return 8'h00;
        if (o == 0) return {7'b0, m_ie};
        if (o == 1) return {4'b0, m_mask};
        if (o == 2) return {4'b0, m_pend};
        if (o == 3) return {(m_phase != 0), 5'b0, act};
        return m_vec[o-4];
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on && reset_n) begin
            chk8("mdl_int_req", {7'b0, int_req}, {7'b0, (m_phase == 1)});
            chk8("mdl_int_en", int_en, {7'b0, m_ie});
            chk8("mdl_int_vec", int_vec, (m_phase == 1) ? m_vec[m_active] : m_last);
            chk8("mdl_r_data", r_data, exp_rdata(addr));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; w_data = d; w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk8(nm, r_data, exp);
    endtask

    task automatic ret_pulse();
        cpu_ret = 1'b1;
        tick();
        cpu_ret = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (int_req) seen = 1;
        end
        chk8(nm, {7'b0, seen}, 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        chk_on = 1'b1;
        tick();
        chk8("rst_int_req", {7'b0, int_req}, 8'h00);
        chk8("rst_int_en", int_en, 8'h00);
        chk8("rst_int_vec", int_vec, 8'h00);
        rd("rst_status", 8'hF3, 8'h00);

        // Single source, exact latency from the irq edge
        wr(8'hF5, 8'h40); wr(8'hF1, 8'h02); wr(8'hF0, 8'h01);
        irq = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 2) irq = 4'b0000;
            chk8("t1_req_timing", {7'b0, int_req}, {7'b0, (c == 3)});
            if (c == 3) chk8("t1_vec", int_vec, 8'h40);
        end
        rd("t1_pend", 8'hF2, 8'h00);
        rd("t1_status", 8'hF3, 8'h81);
        chk8("t1_vec_hold", int_vec, 8'h40);
        ret_pulse();
        rd("t1_status_idle", 8'hF3, 8'h01);

        // Simultaneous sources 0 and 3: priority, then second dispatch
        wr(8'hF1, 8'h0F); wr(8'hF4, 8'h11); wr(8'hF7, 8'h33);
        rd("t2_vec3_rd", 8'hF7, 8'h33);
        rd("t2_above_win", 8'hF8, 8'h00);
        rd("t2_below_win", 8'hEF, 8'h00);
        irq = 4'b1001;
        wait_req("t2_req0_seen");
        chk8("t2_vec0", int_vec, 8'h11);
        tick();
        rd("t2_status0", 8'hF3, 8'h80);
        rd("t2_pend3", 8'hF2, 8'h08);
        ret_pulse();
        wait_req("t2_req3_seen");
        chk8("t2_vec3", int_vec, 8'h33);
        cpu_ret = 1'b1;
        tick();
        cpu_ret = 1'b0;
        rd("t2_ret_in_req_ignored", 8'hF3, 8'h83);
        ret_pulse();

        // Global enable gating and release
        wr(8'hF0, 8'h00); wr(8'hF6, 8'h22);
        irq = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk8("t3_gated", {7'b0, int_req}, 8'h00);
        end
        rd("t3_pend", 8'hF2, 8'h04);
        wr(8'hF0, 8'h01);
        chk8("t3_en_edge", {7'b0, int_req}, 8'h00);
        tick();
        chk8("t3_req", {7'b0, int_req}, 8'h01);
        chk8("t3_vec2", int_vec, 8'h22);
        tick();
        rd("t3_status", 8'hF3, 8'h82);

        // New edge during service waits for cpu_ret
        irq = 4'b0000;
        repeat (3) tick();
        irq = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk8("t4_no_nest", {7'b0, int_req}, 8'h00);
        end
        rd("t4_pend", 8'hF2, 8'h04);
        ret_pulse();
        chk8("t4_idle", {7'b0, int_req}, 8'h00);
        tick();
        chk8("t4_redispatch", {7'b0, int_req}, 8'h01);
        tick();
        ret_pulse();

        // W1C alone clears; W1C colliding with a new edge loses
        wr(8'hF0, 8'h00);
        irq = 4'b0000;
        repeat (3) tick();
        irq = 4'b0100;
        repeat (4) tick();
        rd("t5_pend_set", 8'hF2, 8'h04);
        wr(8'hF2, 8'h04);
        rd("t5_w1c", 8'hF2, 8'h00);
        irq = 4'b0000;
        repeat (3) tick();
        irq = 4'b0100;
        tick();
        tick();
        wr(8'hF2, 8'h04);
        rd("t5_set_wins", 8'hF2, 8'h04);

        // Reset in service
        wr(8'hF0, 8'h01);
        wait_req("t6_req_seen");
        chk8("t6_vec", int_vec, 8'h22);
        tick();
        addr = 8'hF3;
        #1;
        reset_n = 1'b0;
        #1;
        chk8("t6_rst_req", {7'b0, int_req}, 8'h00);
        chk8("t6_rst_en", int_en, 8'h00);
        chk8("t6_rst_vec", int_vec, 8'h00);
        chk8("t6_rst_rdata", r_data, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        rd("t6_status", 8'hF3, 8'h00);
        rd("t6_vec2", 8'hF6, 8'h00);
        rd("t6_pend", 8'hF2, 8'h00);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter BASE, default 8'hF0, SHALL be the base address of the 8-byte register window.
REQ-002 Parameter NIRQ, default 4, SHALL be the number of interrupt sources (fixed at 4 in this revision).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 irq  input  4  SHALL carry asynchronous interrupt sources; a rising edge requests service.
REQ-006 addr  input  8  SHALL be the CPU data-memory address.
REQ-007 w_data  input  8  SHALL be the CPU store data.
REQ-008 w_en  input  1  SHALL be the CPU store strobe (mem_w_en).
REQ-009 r_data  output  8  SHALL be the register read data; 8'h00 outside the window.
REQ-010 cpu_ret  input  1  SHALL be the CPU's return-from-interrupt decode, high for one cycle.
REQ-011 int_req  output  1  SHALL be the interrupt request to the CPU.
REQ-012 int_en  output  8  SHALL be the interrupt-enable byte to the CPU.
REQ-013 int_vec  output  8  SHALL be the handler address to the CPU.

Function
REQ-014 Register map, offsets from BASE: +0 IE (bit0 global enable), +1 MASK[3:0], +2 PEND[3:0] (read; write-1-to-clear), +3 STATUS {busy, 5'b0, active_id[1:0]} (read-only), +4..+7 VEC0..VEC3.
REQ-015 A write SHALL take effect at the rising edge where w_en=1 and addr is in the window; reads SHALL be combinational.
REQ-016 Each irq bit SHALL pass a 2-flop synchronizer and then a rising-edge detector; a detected edge SHALL set its PEND bit at the next edge.
REQ-017 If an edge set and a W1C clear hit the same PEND bit in the same cycle, the set SHALL win.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE->REQ when IE[0]=1 and (PEND & MASK) != 0; the lowest-index eligible source SHALL be selected and latched as active_id.
REQ-020 In REQ: int_req=1 for exactly one cycle; int_vec=VEC[active_id]; the active PEND bit SHALL clear at the REQ->SERVICE edge.
REQ-021 REQ->SERVICE unconditionally after one cycle.
REQ-022 SERVICE->IDLE on cpu_ret=1; no nesting; new edges SHALL accumulate in PEND during SERVICE.
REQ-023 cpu_ret in IDLE or REQ SHALL be ignored.
REQ-024 int_req SHALL be 0 in IDLE and SERVICE; int_vec SHALL hold the last dispatched vector outside REQ.
REQ-025 int_en SHALL equal {7'b0, IE[0]}.
REQ-026 Clearing IE[0] or MASK during SERVICE SHALL NOT abort service; it only gates the next dispatch.
REQ-027 STATUS.busy SHALL be 1 in REQ and SERVICE.
REQ-028 Latency: irq rising before edge k -> PEND set at edge k+2 -> REQ entered at edge k+3 -> CPU vectors at edge k+4.

Reset
REQ-029 On reset_n=0, asynchronously: FSM=IDLE, IE=0, MASK=0, PEND=0, active_id=0, VEC0..3=0, synchronizer and edge flops=0.
REQ-030 Outputs during reset: int_req=0, int_en=8'h00, int_vec=8'h00, r_data=8'h00.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL drop int_req immediately and discard the pending source.

Structure
REQ-032 Package int_ctrl_pkg SHALL hold the FSM state enum, the register offset constants and NIRQ.
REQ-033 One sub-module, irq_sync_edge (2-flop synchronizer plus rising-edge detector, 1 bit), SHALL be instantiated per source.

Verification
REQ-034 VEC1=8'h40, MASK=4'h2, IE=1; pulse irq[1] -> int_req high for one cycle at k+3, int_vec=8'h40, PEND=0 and STATUS=8'h81 afterwards.
REQ-035 MASK=4'hF; irq[3] and irq[0] rise together -> source 0 dispatched first; after cpu_ret, source 3 dispatched with VEC3.
REQ-036 IE=0 with PEND[2]=1 -> no int_req; write IE=1 -> int_req within 1 cycle of the write edge.
REQ-037 irq[2] edge during SERVICE -> no int_req until cpu_ret; then dispatch in the next IDLE cycle.
REQ-038 Write PEND=4'h4 in the same cycle as a new irq[2] edge -> PEND[2] stays 1.
REQ-039 Assert reset_n=0 during SERVICE -> all outputs 0 asynchronously; STATUS=8'h00 after release.
